booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//   Sequential radix-2 Booth multiplier: FSM controller plus iterative add/sub/shift datapath.
//   Replaces the combinational booth_multiplier where area beats latency.
//   Accepts one signed WIDTH x WIDTH operation per start/done handshake and returns a 2*WIDTH signed product.
//   Sits between a host sequencer (start/abort) and downstream consumers of product/done.
// PARAMETERS
//   WIDTH    8    operand width in bits, two's complement. Product is 2*WIDTH. Legal: >= 2.
// PORTS
//   clk           in   1         single clock, rising edge
//   rst_n         in   1         synchronous, active-low reset
//   start         in   1         request a new multiply; sampled only in IDLE
//   abort         in   1         cancel an in-flight multiply
//   multiplier    in   WIDTH     signed multiplier (Booth-scanned operand), sampled with start
//   multiplicand  in   WIDTH     signed multiplicand, sampled with start
//   busy          out  1         high while an operation is in progress
//   done          out  1         one-cycle pulse: product has just updated
//   product       out  2*WIDTH   signed result, held until the next completion or reset
// BEHAVIOUR
//   - Reset (rst_n=0 at a clock edge): state=IDLE; busy=0; done=0; product=0; all internal registers 0.
//     Reset overrides start/abort and wins mid-operation. No done is produced for an aborted or reset op.
//   - States: IDLE -> CALC -> IDLE. There is no separate DONE state.
//   - IDLE:
//       - start=1 at edge 0: latch M=sext(multiplicand) to WIDTH+1 bits; A=0; Q=multiplier; Q_1=0; cnt=0.
//       - Go to CALC, busy=1.
//       - start=0: stay in IDLE.
//   - CALC, one Booth step per edge:
//       - Pair {Q[0],Q_1}: 10 -> A=A-M; 01 -> A=A+M; 00/11 -> no op.
//       - Then arithmetic right shift of {A,Q,Q_1} by 1; cnt++.
//       - A is WIDTH+1 bits so that -(-2^(WIDTH-1)) does not overflow.
//   - Completion:
//       - Triggered at the edge performing step WIDTH (edge WIDTH).
//       - product <= {A,Q}[2*WIDTH-1:0]; done=1 for exactly one cycle; busy=0; state=IDLE.
//       - Latency: done is high in the cycle following edge WIDTH.
//   - start while busy=1: ignored, with no effect on the running op.
//     start high in the done cycle is accepted (back-to-back), giving 1 op per WIDTH+1 cycles.
//   - abort=1 in CALC:
//       - At the next edge: state=IDLE, busy=0, done stays 0, product unchanged.
//       - If abort and completion coincide, abort wins.
//       - abort in IDLE: no effect; abort and start together in IDLE: start ignored.
//   - done and busy are never high in the same cycle.
//   - product changes only on completion edges or reset.
// CONFIGURATION
//   BOOTH_EARLY_TERM_EN
//     Defined:
//       - After step i (1..WIDTH), if Q[WIDTH-1-i:0] and Q_1 are all 0 or all 1, no later step needs an add or sub.
//       - Complete at that same edge with product = ({A,Q} >>> (WIDTH-i))[2*WIDTH-1:0] (arithmetic shift).
//       - Latency varies from 1 to WIDTH steps. Every other rule (done pulse, abort, reset) is unchanged.
//     Undefined: fixed WIDTH-step latency; no termination logic is synthesised.
// TESTING
//   1. multiplier=7, multiplicand=5, start pulse at edge 0 -> done only in the cycle after edge 8; product=16'h0023; busy high for 8 cycles.
//   2. (-7)x(-5) -> 16'h0023; (-7)x5 -> 16'hFFDD; 7x(-5) -> 16'hFFDD; 7x0 -> 16'h0000; 5x1 -> 16'h0005.
//   3. (-128)x(-128) -> 16'h4000; (-128)x127 -> 16'hC080; verify no accumulator overflow.
//   4. start held high throughout -> ops accepted in the done cycle, one done every 9 cycles; a start mid-CALC does not disturb the result.
//   5. After a 16'h0023 result, start 3x3, abort at edge 3 -> busy=0 at edge 4, no done, product stays 16'h0023.
//      Repeat with rst_n=0 at edge 3 -> product=0.
//   6. BOOTH_EARLY_TERM_EN defined:
//        - multiplier=-1, multiplicand=7 -> 16'hFFF9 with done after edge 1.
//        - multiplier=1, multiplicand=5 -> 16'h0005 with done after edge 2.
//      Undefined: both cases complete after edge 8.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-2 Booth multiplier, WIDTH x WIDTH signed -> 2*WIDTH.
// One Booth step per clock after start; done pulses for one cycle when product updates.
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as the unscanned multiplier
// bits can no longer cause an add or subtract.
//
//   state | meaning
//   IDLE  | waiting for start; product holds the last result
//   CALC  | one Booth add/sub + arithmetic shift per clock; cnt = steps done
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state, state_nxt;
  logic [WIDTH:0]       a, a_nxt;
  logic [WIDTH:0]       m, m_nxt;
  logic [WIDTH-1:0]     q, q_nxt;
  logic                 q1, q1_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2*WIDTH-1:0]   prod, prod_nxt;
  logic                 done_r, done_nxt;

  // Booth step results, computed every cycle and used only in CALC
  logic [WIDTH:0]          a_step;
  logic signed [2*WIDTH+1:0] sh;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    fin;
  logic [2*WIDTH-1:0]      res;

`ifdef BOOTH_EARLY_TERM_EN
  logic signed [2*WIDTH:0] acc_full;
  logic                    tail_zero;
  logic                    tail_one;
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      m      <= '0;
      q      <= '0;
      q1     <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      m      <= m_nxt;
      q      <= q_nxt;
      q1     <= q1_nxt;
      cnt    <= cnt_nxt;
      prod   <= prod_nxt;
      done_r <= done_nxt;
    end
  end

  // One Booth step: add/sub on the {Q[0],Q_1} pair, then shift {A,Q,Q_1} right arithmetically
  always_comb begin
    case ({q[0], q1})
      2'b10:   a_step = a - m;
      2'b01:   a_step = a + m;
      default: a_step = a;
    endcase
    sh      = $signed({a_step, q, q1}) >>> 1;
    cnt_inc = cnt + CNT_W'(1);
`ifdef BOOTH_EARLY_TERM_EN
    // Remaining scan pairs are all no-ops when the unscanned bits match Q_1
    tail_zero = 1'b1;
    tail_one  = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < WIDTH - int'(cnt_inc)) begin
        if (sh[k+1]) tail_zero = 1'b0;
        else         tail_one  = 1'b0;
      end
    end
    fin      = sh[0] ? tail_one : tail_zero;
    acc_full = sh[2*WIDTH+1:1];
    res      = (2*WIDTH)'(acc_full >>> (WIDTH - int'(cnt_inc)));
`else
    fin = (cnt_inc == CNT_W'(WIDTH));
    res = sh[2*WIDTH:1];
`endif
  end

  // Next-state and register updates; abort beats completion, start ignored outside IDLE
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    m_nxt     = m;
    q_nxt     = q;
    q1_nxt    = q1;
    cnt_nxt   = cnt;
    prod_nxt  = prod;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          m_nxt     = {multiplicand[WIDTH-1], multiplicand};
          a_nxt     = '0;
          q_nxt     = multiplier;
          q1_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          a_nxt   = sh[2*WIDTH+1:WIDTH+1];
          q_nxt   = sh[WIDTH:1];
          q1_nxt  = sh[0];
          cnt_nxt = cnt_inc;
          if (fin) begin
            prod_nxt  = res;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == CALC);
  assign done    = done_r;
  assign product = prod;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed and random multiplies against an
// arithmetic reference (signed product, latency from the multiplier's bit pattern).
module tb_booth_seq_ctrl;

  localparam int W = 8;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [W-1:0]     multiplier;
  logic [W-1:0]     multiplicand;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int errs   = 0;
  int checks = 0;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] mp, input logic [W-1:0] mc);
    logic signed [2*W-1:0] x, y;
    x = $signed(mp);
    y = $signed(mc);
    return x * y;
  endfunction

  // Steps needed: full W, or with early termination the first i where bits i-1..W-1 agree
  function automatic int ref_lat(input logic [W-1:0] mp);
    int first;
    bit uni;
    first = W;
    for (int i = W; i >= 1; i--) begin
      uni = 1'b1;
      for (int j = i - 1; j < W; j++)
        if (mp[j] != mp[W-1]) uni = 1'b0;
      if (uni) first = i;
    end
    return EARLY ? first : W;
  endfunction

  task automatic run_op(input logic [W-1:0] mp, input logic [W-1:0] mc, input string tag);
    logic [2*W-1:0] prev, exp_p;
    int exp_l, n, bcnt;
    bit got, both, stable;
    exp_p        = ref_prod(mp, mc);
    exp_l        = ref_lat(mp);
    prev         = product;
    start        = 1'b1;
    multiplier   = mp;
    multiplicand = mc;
    tick();
    start        = 1'b0;
    multiplier   = W'($urandom);
    multiplicand = W'($urandom);
    n      = 0;
    bcnt   = busy ? 1 : 0;
    both   = 1'b0;
    stable = (product === prev);
    got    = 1'b0;
    while (!got && n < 4 * W) begin
      tick();
      n++;
      if (busy && done) both = 1'b1;
      if (done) got = 1'b1;
      else begin
        if (busy) bcnt++;
        if (product !== prev) stable = 1'b0;
      end
    end
    chk({tag, "_latency"}, n, exp_l);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_busy_cycles"}, bcnt, exp_l);
    chk({tag, "_busy_done_overlap"}, both, 1'b0);
    chk({tag, "_product_held"}, stable, 1'b1);
    tick();
    chk({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] held;
    int n, m;
    bit got;

    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    multiplier = 8'd7; multiplicand = 8'd5;
    tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_product", product, 16'h0000);
    rst_n = 1'b1; start = 1'b0;
    tick();

    run_op(8'd7, 8'd5, "p7x5");
    chk("p7x5_literal", product, 16'h0023);
    run_op(-8'sd7, -8'sd5, "n7xn5");
    chk("n7xn5_literal", product, 16'h0023);
    run_op(-8'sd7, 8'd5, "n7x5");
    chk("n7x5_literal", product, 16'hFFDD);
    run_op(8'd7, -8'sd5, "p7xn5");
    run_op(8'd7, 8'd0, "p7x0");
    run_op(8'd5, 8'd1, "p5x1");
    run_op(8'h80, 8'h80, "min_x_min");
    chk("min_x_min_literal", product, 16'h4000);
    run_op(8'h80, 8'h7F, "min_x_max");
    chk("min_x_max_literal", product, 16'hC080);
    run_op(8'hFF, 8'd7, "m1x7");
    chk("m1x7_latency_rule", ref_lat(8'hFF), EARLY ? 1 : 8);
    run_op(8'd1, 8'd5, "p1x5");
    run_op(8'h7F, 8'h80, "max_x_min");

    for (int r = 0; r < 24; r++)
      run_op(W'($urandom), W'($urandom), "rand");

    // Start held high: next op accepted in the done cycle; mid-CALC operand changes ignored
    a1 = -8'sd93; b1 = 8'd77; a2 = 8'd100; b2 = -8'sd3;
    start = 1'b1; multiplier = a1; multiplicand = b1;
    tick();
    multiplier = a2; multiplicand = b2;
    n = 0; got = 1'b0;
    while (!got && n < 4 * W) begin
      tick(); n++;
      if (done) got = 1'b1;
    end
    chk("held_lat1", n, ref_lat(a1));
    chk("held_prod1", product, ref_prod(a1, b1));
    m = 0; got = 1'b0;
    while (!got && m < 4 * W) begin
      tick(); m++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("held_gap", m, ref_lat(a2) + 1);
    chk("held_prod2", product, ref_prod(a2, b2));
    tick();

    // Abort mid-operation: no done, product kept
    run_op(8'd7, 8'd5, "pre_abort");
    held = product;
    start = 1'b1; multiplier = 8'h43; multiplicand = 8'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_product", product, held);
    got = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done || busy) got = 1'b1;
    end
    chk("abort_quiet", got, 1'b0);
    chk("abort_product_later", product, 16'h0023);

    // Abort coinciding with the completion edge
    start = 1'b1; multiplier = 8'h43; multiplicand = 8'd9;
    tick();
    start = 1'b0;
    for (int i = 1; i < ref_lat(8'h43); i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_at_end_done", done, 1'b0);
    chk("abort_at_end_busy", busy, 1'b0);
    chk("abort_at_end_product", product, held);

    // Abort and start together in IDLE: start ignored
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", busy, 1'b0);
    tick();

    // Reset mid-operation clears product and suppresses done
    start = 1'b1; multiplier = 8'h43; multiplicand = 8'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_product", product, 16'h0000);
    tick();
    run_op(8'd3, 8'd3, "post_reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
